// File: rtl/edge_frame_sequencer.sv
// Frame-level controller for the 3x3 Sobel gradient engine: fetches each window
// from pixel memory, runs the engine once per window and writes the result image.
module edge_frame_sequencer #(
  parameter int unsigned          IMG_W    = 16,
  parameter int unsigned          IMG_H    = 16,
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    OUT_BASE = ADDR_W'(32'h8000),
  parameter int unsigned          TIMEOUT  = 63
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_valid,
  input  logic [7:0]        i_rd_data,
  output logic              o_wr_req,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  input  logic              i_wr_ack,
  output logic              o_gradient_start,
  output logic [71:0]       o_window,
  input  logic              i_gradient_data_ready,
  input  logic [7:0]        i_processed_sum
);

  localparam int unsigned C_W = (IMG_W > 3) ? $clog2(IMG_W - 2) : 1;
  localparam int unsigned R_W = (IMG_H > 3) ? $clog2(IMG_H - 2) : 1;
  localparam int unsigned T_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [C_W-1:0] C_LAST = C_W'(IMG_W - 3);
  localparam logic [R_W-1:0] R_LAST = R_W'(IMG_H - 3);
  localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_WAIT_RDY, S_WRITE, S_ADVANCE, S_DONE, S_ABORT
  } state_t;

  state_t            state_q, state_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [C_W-1:0]    c_q, c_d;
  logic [1:0]        frow_q, frow_d;
  logic [1:0]        fcol_q, fcol_d;
  logic [8:0][7:0]   win_q, win_d;
  logic [T_W-1:0]    wcnt_q, wcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              gstart_q, gstart_d;

  logic [ADDR_W-1:0] rd_row, rd_col, rd_addr_calc, wr_addr_calc;
  logic [3:0]        widx;

  // Pixel being fetched sits at (r+frow, c+fcol) and lands in window slot frow*3+fcol
  always_comb begin
    rd_row       = ADDR_W'(r_q) + ADDR_W'(frow_q);
    rd_col       = ADDR_W'(c_q) + ADDR_W'(fcol_q);
    rd_addr_calc = rd_row * ADDR_W'(IMG_W) + rd_col;
    wr_addr_calc = OUT_BASE + ADDR_W'(r_q) * ADDR_W'(IMG_W - 2) + ADDR_W'(c_q);
    widx         = 4'(frow_q) * 4'd3 + 4'(fcol_q);
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    frow_d    = frow_q;
    fcol_d    = fcol_q;
    win_d     = win_q;
    wcnt_d    = wcnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    gstart_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          busy_d  = 1'b1;
          err_d   = 1'b0;
          r_d     = '0;
          c_d     = '0;
          frow_d  = '0;
          fcol_d  = '0;
          state_d = S_FETCH;
        end
      end
      // One read in flight; a dead cycle separates consecutive requests
      S_FETCH: begin
        if (!rd_req_q) begin
          rd_req_d  = 1'b1;
          rd_addr_d = rd_addr_calc;
        end else if (i_rd_valid) begin
          rd_req_d    = 1'b0;
          win_d[widx] = i_rd_data;
          if (frow_q == 2'd2) begin
            frow_d = '0;
            if (fcol_q == 2'd2) state_d = S_START;
            else                fcol_d  = fcol_q + 2'd1;
          end else begin
            frow_d = frow_q + 2'd1;
          end
        end
      end
      S_START: begin
        if (!i_gradient_data_ready) begin
          gstart_d = 1'b1;
          wcnt_d   = '0;
          state_d  = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (i_gradient_data_ready) begin
          wr_data_d = i_processed_sum;
          wr_addr_d = wr_addr_calc;
          wr_req_d  = 1'b1;
          state_d   = S_WRITE;
        end else if (wcnt_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
        end else begin
          wcnt_d = wcnt_q + T_W'(1);
        end
      end
      S_WRITE: begin
        if (i_wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = S_ADVANCE;
        end
      end
      // Same row: slide window left and fetch only the new right column
      S_ADVANCE: begin
        state_d = S_FETCH;
        frow_d  = '0;
        if (c_q < C_LAST) begin
          c_d      = c_q + C_W'(1);
          fcol_d   = 2'd2;
          win_d[0] = win_q[1];
          win_d[1] = win_q[2];
          win_d[3] = win_q[4];
          win_d[4] = win_q[5];
          win_d[6] = win_q[7];
          win_d[7] = win_q[8];
        end else begin
          c_d    = '0;
          fcol_d = '0;
          if (r_q < R_LAST) r_d     = r_q + R_W'(1);
          else              state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      frow_q    <= '0;
      fcol_q    <= '0;
      win_q     <= '0;
      wcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      gstart_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      frow_q    <= frow_d;
      fcol_q    <= fcol_d;
      win_q     <= win_d;
      wcnt_q    <= wcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      gstart_q  <= gstart_d;
    end
  end

  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_err            = err_q;
  assign o_rd_req         = rd_req_q;
  assign o_rd_addr        = rd_addr_q;
  assign o_wr_req         = wr_req_q;
  assign o_wr_addr        = wr_addr_q;
  assign o_wr_data        = wr_data_q;
  assign o_gradient_start = gstart_q;
  assign o_window         = win_q;

endmodule

// File: doc/edge_frame_sequencer.md
Name: edge_frame_sequencer

Overview:
- Frame-level controller for the 3x3 Sobel gradient engine.
- Walks an IMG_W x IMG_H 8-bit greyscale image held in a single-ported pixel memory and assembles each 3x3 window.
- Starts the engine once per window and collects its 8-bit saturated result.
- Writes the results as a (IMG_W-2) x (IMG_H-2) output image at OUT_BASE. It sits between the memory arbiter and the gradient engine.

Parameters:
IMG_W, 16, image width in pixels (>=3)
IMG_H, 16, image height in pixels (>=3)
ADDR_W, 16, memory address width
OUT_BASE, 16'h8000, word address of output pixel (0,0)
TIMEOUT, 63, max cycles to wait for engine ready before abort

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
i_start  in  1  pulse: begin frame (ignored while busy)
o_busy  out  1  high from accepted i_start until done/abort
o_done  out  1  one-cycle pulse after last output write acked
o_err  out  1  sticky timeout flag, cleared by next accepted i_start
o_rd_req  out  1  read request, held until i_rd_valid
o_rd_addr  out  ADDR_W  read address = row*IMG_W+col
i_rd_valid  in  1  read data valid (any latency >=1)
i_rd_data  in  8  read data
o_wr_req  out  1  write request, held until i_wr_ack
o_wr_addr  out  ADDR_W  write address
o_wr_data  out  8  write data
i_wr_ack  in  1  write accepted
o_gradient_start  out  1  one-cycle engine start pulse
o_window  out  72  P0 at [7:0] .. P8 at [71:64]; P0-P2 top row L->R, P3-P5 middle, P6-P8 bottom
i_gradient_data_ready  in  1  engine result valid (held 2 cycles by engine)
i_processed_sum  in  8  engine result

Behaviour:
- Reset: all outputs 0, state IDLE, counters and window registers 0. Reset mid-frame aborts with no further requests; no o_done.
- States: IDLE, FETCH, START, WAIT_RDY, WRITE, ADVANCE, DONE, ABORT.
- IDLE: on i_start set o_busy, clear o_err, set r=0/c=0, full-fetch mode -> FETCH.
- FETCH: one outstanding read. o_rd_req/o_rd_addr stay stable until i_rd_valid; data is captured on the i_rd_valid cycle. o_rd_req deasserts the same cycle; the next request is issued the following cycle.
  - Full fetch (c==0): 9 reads, column-major (col c rows r..r+2, then c+1, then c+2).
  - Incremental fetch (c>0): window shifts left one column (P0<=P1, P1<=P2, P3<=P4, P4<=P5, P6<=P7, P7<=P8) on entry. Then 3 reads of col c+2 rows r..r+2 into P2, P5, P8.
  - After the last capture -> START.
- o_window must stay stable from the start pulse until the result is captured; the engine samples P inputs over many cycles.
- START: if i_gradient_data_ready==1, stall without pulsing. Otherwise pulse o_gradient_start for exactly 1 cycle -> WAIT_RDY, wait counter cleared.
- WAIT_RDY:
  - On the first cycle with i_gradient_data_ready==1, latch i_processed_sum -> WRITE. The second ready cycle is ignored.
  - If the counter reaches TIMEOUT with no ready: set o_err -> ABORT.
- WRITE: o_wr_req with o_wr_addr = OUT_BASE + r*(IMG_W-2) + c and o_wr_data = latched sum. Hold until i_wr_ack, then deassert -> ADVANCE.
- ADVANCE:
  - If c < IMG_W-3: c++, incremental fetch.
  - Else c=0; if r < IMG_H-3: r++, full fetch; else -> DONE.
  - Then -> FETCH.
- DONE: o_done pulse 1 cycle, o_busy low -> IDLE.
- ABORT: o_busy low, no o_done -> IDLE.
- i_start while o_busy is ignored. i_rd_valid outside an outstanding read is ignored. i_wr_ack outside WRITE is ignored.
- Read count per frame: (IMG_H-2) * (9 + 3*(IMG_W-3)). Write count: (IMG_W-2)*(IMG_H-2).
- Counter widths: ceil(log2) of their ranges. Address arithmetic is unsigned, truncated to ADDR_W.

Test Plan:
- IMG_W=IMG_H=3, columns 0/10/20 (all rows), 1-cycle memory latency, real engine -> 9 reads, 1 write addr 16'h8000 data 80, o_done pulse, o_err=0.
- 3x3, columns 0/100/100 -> Gx=400 saturates -> write data 255. Uniform image 50 -> write data 0.
- IMG_W=IMG_H=4, random pixels -> 24 reads (12 per row), 4 writes at 8000..8003 matching golden Sobel model, addresses row-major.
- Random 0-5 cycle delays on i_rd_valid and i_wr_ack, 8x6 image -> results identical to zero-delay run. o_rd_addr/o_wr_data stable while req held; o_window stable start->ready.
- Engine model never asserts ready -> o_err=1 exactly TIMEOUT cycles after start pulse, o_busy=0, no o_done, no write. Next i_start clears o_err.
- n_rst asserted mid-WAIT_RDY -> all outputs 0 immediately. i_start pulsed while busy has no effect. Restart completes a correct frame.
